cnt_cmd_seq: RTL
================

Name: cnt_cmd_seq

Overview:
- Command sequencer that sits directly upstream of the 8-bit up/down load counter and drives its control pins: ld_cnt_, updn_cnt, count_enb and data_in.
- Accepts LOAD / UP / DOWN / HOLD commands over a valid/ready interface.
- Buffers commands in a small FIFO and executes them back-to-back, one counter control cycle per clock.
- Gives the counter's property checks a deterministic, scriptable stimulus source.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- AW, 2, FIFO pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept a command.
- cmd_op  input  2  command opcode: 00 LOAD, 01 UP, 10 DOWN, 11 HOLD.
- cmd_arg  input  8  LOAD value, or cycle count for UP/DOWN/HOLD.
- ld_cnt_  output  1  counter load, active-low.
- updn_cnt  output  1  counter direction, 1 = up.
- count_enb  output  1  counter enable.
- data_in  output  8  counter load data.
- busy  output  1  FSM not idle, or FIFO not empty.
- done  output  1  one-cycle pulse when a command completes.
- fifo_level  output  AW+1  number of queued commands.

Behaviour:
- Reset values: ld_cnt_=1, updn_cnt=0, count_enb=0, data_in=0, busy=0, done=0, fifo_level=0, cmd_ready=1.
- Reset is synchronous and takes effect at the sampling edge, including mid-command. It flushes the FIFO, drops the in-flight command, forces the FSM to IDLE and clears the shadow count. No done pulse is issued for a flushed command.
- Handshake:
  - A push occurs when cmd_valid && cmd_ready at a posedge.
  - cmd_ready = (fifo_level != DEPTH) and does not depend on a same-cycle pop.
  - When full, cmd_valid is ignored; the source holds it.
  - Simultaneous push and pop when not full: fifo_level is unchanged.
- FSM states: IDLE, EXEC.
  - IDLE -> EXEC at a posedge when the FIFO is non-empty. That edge pops the head into cur_op / cur_arg and sets rem.
  - EXEC -> EXEC (next command) when the current command ends and the FIFO is non-empty. No bubble cycle.
  - EXEC -> IDLE when the current command ends and the FIFO is empty.
- Latency: a command pushed at edge k into an empty, idle block enters EXEC at edge k+1. Its first control cycle is sampled by the counter at edge k+2.
- Outputs are decoded from registered state. Each EXEC cycle is one counter control cycle:
  - LOAD: exactly 1 cycle with ld_cnt_=0, data_in=cur_arg, count_enb=0.
  - UP: ld_cnt_=1, count_enb=1, updn_cnt=1.
  - DOWN: ld_cnt_=1, count_enb=1, updn_cnt=0.
  - HOLD: ld_cnt_=1, count_enb=0.
- Duration of UP/DOWN/HOLD: max(cur_arg, 1) cycles. An arg of 0 executes one hold cycle (count_enb=0).
- rem is an 8-bit down-counter. The command ends in the cycle where rem==1; rem never wraps.
- Outside EXEC: ld_cnt_=1, count_enb=0, updn_cnt=0, data_in=0.
- done is registered high for one cycle, in the cycle after each command's last control cycle. Back-to-back commands give back-to-back done pulses.
- busy = (state==EXEC) || (fifo_level != 0).
- Shadow count (8 bits): loaded with cur_arg on a LOAD cycle, +1 on an UP cycle, -1 on a DOWN cycle, all modulo 256.
  - Without SEQ_SAT_EN the shadow is unused and wrap is allowed.
  - The counter's own reset must be applied together with rst so that the shadow matches data_out.

Optional Feature:
- Macro: SEQ_SAT_EN.
- Defined:
  - An UP cycle with shadow==8'hFF is issued with count_enb=0.
  - A DOWN cycle with shadow==8'h00 is issued with count_enb=0.
  - The counter therefore saturates instead of wrapping.
  - Command duration and rem decrement are unchanged.
- Undefined: the counter wraps 8'hFF->8'h00 and 8'h00->8'hFF.

Test Plan:
- Reset, then LOAD 8'h5A -> one cycle with ld_cnt_=0 and data_in=8'h5A, counter samples it at k+2. data_out=8'h5A, then done pulses once; busy falls the cycle after.
- LOAD 8'h10 then UP 3, pushed back-to-back -> 1 load cycle then 3 count_enb=1 cycles, updn_cnt=1, no gap. data_out goes 10,11,12,13; two done pulses.
- Push DEPTH+1 commands with the FSM busy on HOLD 20 -> cmd_ready=0 at fifo_level=DEPTH and the extra command is held off. It is accepted after the first pop; none are lost.
- LOAD 8'hFE then UP 4 -> with SEQ_SAT_EN, data_out ends at 8'hFF with count_enb=0 for the last 3 cycles. Without the macro, data_out ends at 8'h02.
- DOWN 0 and HOLD 0 -> each executes exactly 1 cycle with count_enb=0 and produces one done pulse.
- rst=1 in the 2nd cycle of UP 10 with 2 commands queued -> at the next edge fifo_level=0, count_enb=0, no done pulse. Commands pushed after reset execute normally.

Source files
------------

// File: rtl/cnt_cmd_seq.sv
// cnt_cmd_seq: FIFO-buffered LOAD/UP/DOWN/HOLD sequencer that drives an 8-bit up/down load counter.
// Optional macro SEQ_SAT_EN: suppress count enables that would wrap the counter (saturating mode).
module cnt_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_arg,
  output logic        ld_cnt_,
  output logic        updn_cnt,
  output logic        count_enb,
  output logic [7:0]  data_in,
  output logic        busy,
  output logic        done,
  output logic [AW:0] fifo_level
);

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_HOLD = 2'b11
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_e;

  typedef struct packed {
    op_e        op;
    logic [7:0] arg;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  cmd_t          cur;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  state_e        state;
  state_e        state_nxt;
  logic [7:0]    rem;
  logic          done_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          last;
  logic          sat_block;

  assign full      = (level == (AW+1)'(DEPTH));
  assign empty     = (level == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign last      = (state == S_EXEC) && (rem == 8'd1);
  // A pop happens either to start from idle or to chain straight into the next command.
  assign pop       = !empty && ((state == S_IDLE) || last);
  assign head      = mem[rd_ptr];

  // NOTE: storage array has no reset; validity is tracked solely by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: op_e'(cmd_op), arg: cmd_arg};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // NOTE: next-state logic assigns its default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!empty) state_nxt = S_EXEC;
      S_EXEC:  if (last && empty) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cur    <= '0;
      rem    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= last;
      if (pop) begin
        cur <= head;
        // LOAD is always one cycle; a zero count still occupies one hold cycle.
        rem <= (head.op == OP_LOAD || head.arg == 8'd0) ? 8'd1 : head.arg;
      end else if (state == S_EXEC && !last) begin
        rem <= rem - 8'd1;
      end
    end
  end

`ifdef SEQ_SAT_EN
  logic [7:0] shadow;

  // Tracks the counter's value so boundary steps can be suppressed before they wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
    end else if (state == S_EXEC) begin
      case (cur.op)
        OP_LOAD: shadow <= cur.arg;
        OP_UP:   if (count_enb) shadow <= shadow + 8'd1;
        OP_DOWN: if (count_enb) shadow <= shadow - 8'd1;
        default: shadow <= shadow;
      endcase
    end
  end

  assign sat_block = ((cur.op == OP_UP)   && (shadow == 8'hFF)) ||
                     ((cur.op == OP_DOWN) && (shadow == 8'h00));
`else
  assign sat_block = 1'b0;
`endif

  always_comb begin
    ld_cnt_   = 1'b1;
    updn_cnt  = 1'b0;
    count_enb = 1'b0;
    data_in   = 8'h00;
    if (state == S_EXEC) begin
      case (cur.op)
        OP_LOAD: begin
          ld_cnt_ = 1'b0;
          data_in = cur.arg;
        end
        OP_UP: begin
          updn_cnt  = 1'b1;
          count_enb = (cur.arg != 8'd0) && !sat_block;
        end
        OP_DOWN: begin
          count_enb = (cur.arg != 8'd0) && !sat_block;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state == S_EXEC) || !empty;
  assign done       = done_q;
  assign fifo_level = level;

endmodule
